// File: rtl/vga_pkg.sv
// Shared constants, pattern codes, box FSM states and colour helpers for the
// 1280x720 VGA pattern renderer.
package vga_pkg;

    localparam int H_ACTIVE   = 1280;
    localparam int V_ACTIVE   = 720;
    localparam int H_FP       = 110;
    localparam int H_SYNC     = 40;
    localparam int H_BP       = 220;
    localparam int V_FP       = 5;
    localparam int V_SYNC     = 5;
    localparam int V_BP       = 20;
    localparam int XW         = 11;
    localparam int YW         = 10;
    localparam int BOX_SIZE   = 64;
    localparam int STEP       = 4;
    localparam int CHECK_LOG2 = 5;
    localparam int BAR_W      = H_ACTIVE / 8;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_BOX   = 2'd2,
        PAT_GRAD  = 2'd3
    } pat_e;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_MOVE_X = 2'd1,
        S_MOVE_Y = 2'd2
    } box_state_e;

    // Colours packed as {R[2:0], G[2:0], B[1:0]}
    localparam logic [7:0] COL_WHITE   = 8'b111_111_11;
    localparam logic [7:0] COL_YELLOW  = 8'b111_111_00;
    localparam logic [7:0] COL_CYAN    = 8'b000_111_11;
    localparam logic [7:0] COL_GREEN   = 8'b000_111_00;
    localparam logic [7:0] COL_MAGENTA = 8'b111_000_11;
    localparam logic [7:0] COL_RED     = 8'b111_000_00;
    localparam logic [7:0] COL_BLUE    = 8'b000_000_11;
    localparam logic [7:0] COL_BLACK   = 8'b000_000_00;
    localparam logic [7:0] COL_DKBLUE  = 8'b000_000_01;

    function automatic logic [7:0] bar_colour(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = COL_WHITE;
            3'd1:    c = COL_YELLOW;
            3'd2:    c = COL_CYAN;
            3'd3:    c = COL_GREEN;
            3'd4:    c = COL_MAGENTA;
            3'd5:    c = COL_RED;
            3'd6:    c = COL_BLUE;
            default: c = COL_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position FSM: moves X then Y by STEP once per frame start,
// reflecting off the active-area edges.
module vga_box_mover
    import vga_pkg::*;
(
    input  logic          clk_pixel,
    input  logic          rst_n,
    input  logic          frame_start,
    output logic [XW-1:0] box_x,
    output logic [YW-1:0] box_y
);

    localparam logic [XW:0] X_LIM = (XW+1)'(H_ACTIVE - BOX_SIZE);
    localparam logic [YW:0] Y_LIM = (YW+1)'(V_ACTIVE - BOX_SIZE);

    box_state_e    state_r;
    logic [XW-1:0] box_x_r;
    logic [YW-1:0] box_y_r;
    logic          dir_x_left_r;
    logic          dir_y_up_r;
    logic [XW:0]   x_fwd_s;
    logic [YW:0]   y_fwd_s;

    // Forward candidates computed one bit wider so the limit compare cannot wrap
    always_comb begin
        x_fwd_s = {1'b0, box_x_r} + (XW+1)'(STEP);
        y_fwd_s = {1'b0, box_y_r} + (YW+1)'(STEP);
    end

    // Box FSM: one axis per cycle after a frame start, new edges ignored while moving
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            state_r      <= S_WAIT;
            box_x_r      <= '0;
            box_y_r      <= '0;
            dir_x_left_r <= 1'b0;
            dir_y_up_r   <= 1'b0;
        end else begin
            case (state_r)
                S_WAIT: begin
                    if (frame_start) begin
                        state_r <= S_MOVE_X;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_MOVE_X: begin
                    if (!dir_x_left_r) begin
                        if (x_fwd_s >= X_LIM) begin
                            box_x_r      <= X_LIM[XW-1:0];
                            dir_x_left_r <= 1'b1;
                        end else begin
                            box_x_r <= x_fwd_s[XW-1:0];
                        end
                    end else begin
                        if ({1'b0, box_x_r} <= (XW+1)'(STEP)) begin
                            box_x_r      <= '0;
                            dir_x_left_r <= 1'b0;
                        end else begin
                            box_x_r <= box_x_r - XW'(STEP);
                        end
                    end
                    state_r <= S_MOVE_Y;
                end
                S_MOVE_Y: begin
                    if (!dir_y_up_r) begin
                        if (y_fwd_s >= Y_LIM) begin
                            box_y_r    <= Y_LIM[YW-1:0];
                            dir_y_up_r <= 1'b1;
                        end else begin
                            box_y_r <= y_fwd_s[YW-1:0];
                        end
                    end else begin
                        if ({1'b0, box_y_r} <= (YW+1)'(STEP)) begin
                            box_y_r    <= '0;
                            dir_y_up_r <= 1'b0;
                        end else begin
                            box_y_r <= box_y_r - YW'(STEP);
                        end
                    end
                    state_r <= S_WAIT;
                end
                default: state_r <= S_WAIT;
            endcase
        end
    end

    assign box_x = box_x_r;
    assign box_y = box_y_r;

endmodule

// File: rtl/vga_pattern_renderer.sv
// Pixel stage after the VGA timing generator: two-stage pipeline producing
// registered 3:3:2 test-pattern colour with syncs re-aligned to it.
module vga_pattern_renderer
    import vga_pkg::*;
(
    input  logic          clk_pixel,
    input  logic          rst_n,
    input  logic [XW-1:0] x_in,
    input  logic [YW-1:0] y_in,
    input  logic          de_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic [1:0]    pat_sel,
    output logic          HSync,
    output logic          VSync,
    output logic [2:0]    Red,
    output logic [2:0]    Green,
    output logic [1:0]    Blue
);

    logic          vsync_d_r;
    logic          armed_r;
    logic          frame_start_s;
    pat_e          pat_cur_r;
    logic [7:0]    frame_cnt_r;
    logic [XW-1:0] x1_r;
    logic [YW-1:0] y1_r;
    logic          de1_r;
    logic          hs1_r;
    logic          vs1_r;
    logic          hsync_r;
    logic          vsync_r;
    logic [7:0]    colour_r;
    logic [XW-1:0] box_x_s;
    logic [YW-1:0] box_y_s;
    logic [2:0]    bar_idx_s;
    logic          in_box_s;
    logic [7:0]    pix_s;

    // armed_r blocks a false edge when vsync_in is already high as reset releases
    assign frame_start_s = vsync_in & ~vsync_d_r & armed_r;

    vga_box_mover u_box (
        .clk_pixel   (clk_pixel),
        .rst_n       (rst_n),
        .frame_start (frame_start_s),
        .box_x       (box_x_s),
        .box_y       (box_y_s)
    );

    // Pattern term selection from the stage-1 registers
    always_comb begin
        bar_idx_s = (x1_r >= XW'(7 * BAR_W)) ? 3'd7 : 3'(x1_r / XW'(BAR_W));
        in_box_s  = ({1'b0, x1_r} >= {1'b0, box_x_s}) &&
                    ({1'b0, x1_r} <  ({1'b0, box_x_s} + (XW+1)'(BOX_SIZE))) &&
                    ({1'b0, y1_r} >= {1'b0, box_y_s}) &&
                    ({1'b0, y1_r} <  ({1'b0, box_y_s} + (YW+1)'(BOX_SIZE)));
        case (pat_cur_r)
            PAT_BARS:  pix_s = bar_colour(bar_idx_s);
            PAT_CHECK: pix_s = (x1_r[CHECK_LOG2] ^ y1_r[CHECK_LOG2]) ? COL_WHITE : COL_BLACK;
            PAT_BOX:   pix_s = in_box_s ? COL_RED : COL_DKBLUE;
            PAT_GRAD:  pix_s = {x1_r[7:5], y1_r[7:5], frame_cnt_r[7:6]};
            default:   pix_s = COL_BLACK;
        endcase
    end

    // Frame-start edge detect, pattern latch and frame counter
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            vsync_d_r   <= 1'b0;
            armed_r     <= 1'b0;
            pat_cur_r   <= PAT_BARS;
            frame_cnt_r <= 8'd0;
        end else begin
            vsync_d_r <= vsync_in;
            armed_r   <= armed_r | ~vsync_in;
            if (frame_start_s) begin
                pat_cur_r   <= pat_e'(pat_sel);
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                pat_cur_r   <= pat_cur_r;
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Two-stage pixel pipeline: S1 captures position/syncs, S2 captures colour
    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            x1_r     <= '0;
            y1_r     <= '0;
            de1_r    <= 1'b0;
            hs1_r    <= 1'b0;
            vs1_r    <= 1'b0;
            hsync_r  <= 1'b0;
            vsync_r  <= 1'b0;
            colour_r <= 8'd0;
        end else begin
            x1_r     <= x_in;
            y1_r     <= y_in;
            de1_r    <= de_in;
            hs1_r    <= hsync_in;
            vs1_r    <= vsync_in;
            hsync_r  <= hs1_r;
            vsync_r  <= vs1_r;
            colour_r <= de1_r ? pix_s : 8'd0;
        end
    end

    assign HSync = hsync_r;
    assign VSync = vsync_r;
    assign Red   = colour_r[7:5];
    assign Green = colour_r[4:2];
    assign Blue  = colour_r[1:0];

endmodule

// File: tb/tb_vga_pattern_renderer.sv
// Directed self-checking bench for vga_pattern_renderer: reset, latency,
// patterns, pattern latch, box bounce and reset with vsync held high.
module tb_vga_pattern_renderer;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic        de_in;
    logic        hsync_in;
    logic        vsync_in;
    logic [1:0]  pat_sel;
    logic        HSync;
    logic        VSync;
    logic [2:0]  Red;
    logic [2:0]  Green;
    logic [1:0]  Blue;

    int checks = 0;
    int errors = 0;
    int nframes = 0;

    vga_pattern_renderer dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .x_in      (x_in),
        .y_in      (y_in),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .pat_sel   (pat_sel),
        .HSync     (HSync),
        .VSync     (VSync),
        .Red       (Red),
        .Green     (Green),
        .Blue      (Blue)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one pixel, wait the two-cycle latency, compare packed RGB
    task automatic px(input string tag, input int x, input int y, input logic [7:0] exp);
        x_in  = 11'(x);
        y_in  = 10'(y);
        de_in = 1'b1;
        tick(2);
        chk(tag, {24'd0, Red, Green, Blue}, {24'd0, exp});
    endtask

    task automatic frame_pulse();
        vsync_in = 1'b1;
        tick(1);
        vsync_in = 1'b0;
        tick(3);
        nframes++;
    endtask

    initial begin
        rst_n    = 1'b0;
        x_in     = 11'd200;
        y_in     = 10'd300;
        de_in    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        pat_sel  = 2'd2;
        tick(5);
        chk("rst_hsync", {31'd0, HSync}, 32'd0);
        chk("rst_vsync", {31'd0, VSync}, 32'd0);
        chk("rst_rgb", {24'd0, Red, Green, Blue}, 32'd0);

        hsync_in = 1'b0;
        vsync_in = 1'b0;
        de_in    = 1'b0;
        pat_sel  = 2'd0;
        rst_n    = 1'b1;
        tick(1);
        chk("rst_box_x", {21'd0, dut.u_box.box_x}, 32'd0);
        chk("rst_box_y", {22'd0, dut.u_box.box_y}, 32'd0);

        // Latency: one-cycle hsync pulse and de=0 blanking
        x_in     = 11'd0;
        hsync_in = 1'b1;
        tick(1);
        hsync_in = 1'b0;
        chk("hs_t1", {31'd0, HSync}, 32'd0);
        tick(1);
        chk("hs_t2", {31'd1, HSync} & 32'd1, 32'd1);
        chk("de0_rgb", {24'd0, Red, Green, Blue}, 32'd0);
        tick(1);
        chk("hs_t3", {31'd0, HSync}, 32'd0);
        vsync_in = 1'b1;
        tick(2);
        chk("vs_t2", {31'd0, VSync}, 32'd1);
        vsync_in = 1'b0;
        tick(3);
        nframes++;

        // Colour bars
        px("bar_x0", 0, 10, 8'hFF);
        px("bar_x159", 159, 10, 8'hFF);
        px("bar_x160", 160, 10, 8'hFC);
        px("bar_x1119", 1119, 10, 8'h03);
        px("bar_x1279", 1279, 10, 8'h00);

        // Pattern latch: pat_sel change mid-frame has no effect until vsync rises
        pat_sel = 2'd1;
        px("latch_hold", 160, 10, 8'hFC);
        frame_pulse();
        px("chk_32_0", 32, 0, 8'hFF);
        px("chk_32_32", 32, 32, 8'h00);
        px("chk_0_32", 0, 32, 8'hFF);

        // Gradient: frame_cnt is 3 here, so blue = 0
        pat_sel = 2'd3;
        frame_pulse();
        chk("frame_cnt3", {24'd0, dut.frame_cnt_r}, 32'd3);
        px("grad", 224, 64, 8'hE8);

        // Bounce
        pat_sel = 2'd2;
        while (nframes < 164) frame_pulse();
        chk("y164", {22'd0, dut.u_box.box_y}, 32'd656);
        chk("x164", {21'd0, dut.u_box.box_x}, 32'd656);
        px("box_in_164", 656, 719, 8'hE0);
        px("box_out_164", 655, 700, 8'h01);
        frame_pulse();
        chk("y165", {22'd0, dut.u_box.box_y}, 32'd652);
        while (nframes < 304) frame_pulse();
        chk("x304", {21'd0, dut.u_box.box_x}, 32'd1216);
        chk("y304", {22'd0, dut.u_box.box_y}, 32'd96);
        px("box_edge_304", 1279, 96, 8'hE0);
        px("box_left_304", 1215, 96, 8'h01);
        frame_pulse();
        chk("x305", {21'd0, dut.u_box.box_x}, 32'd1212);
        chk("y305", {22'd0, dut.u_box.box_y}, 32'd92);
        while (nframes < 310) frame_pulse();
        chk("x310", {21'd0, dut.u_box.box_x}, 32'd1192);

        // Reset mid-frame with vsync held high
        rst_n    = 1'b0;
        vsync_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("rv_cnt", {24'd0, dut.frame_cnt_r}, 32'd0);
        chk("rv_box_x", {21'd0, dut.u_box.box_x}, 32'd0);
        chk("rv_box_y", {22'd0, dut.u_box.box_y}, 32'd0);
        vsync_in = 1'b0;
        tick(1);
        vsync_in = 1'b1;
        tick(3);
        chk("rv_cnt_after", {24'd0, dut.frame_cnt_r}, 32'd1);
        chk("rv_box_after", {21'd0, dut.u_box.box_x}, 32'd4);

        // Second edge during S_MOVE_Y: counted, but box moves only once
        vsync_in = 1'b0;
        tick(1);
        vsync_in = 1'b1;
        tick(1);
        vsync_in = 1'b0;
        tick(1);
        vsync_in = 1'b1;
        tick(1);
        vsync_in = 1'b0;
        tick(3);
        chk("busy_cnt", {24'd0, dut.frame_cnt_r}, 32'd3);
        chk("busy_box_x", {21'd0, dut.u_box.box_x}, 32'd8);
        chk("busy_box_y", {22'd0, dut.u_box.box_y}, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
